// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, price table and selection widths for the vending controller.
package vending_pkg;
   typedef enum logic [1:0] {IDLE, CREDIT, DONE} state_t;
   localparam int LETTER_W = 2;
   localparam int NUMBER_W = 2;
   localparam int SEL_W = LETTER_W + NUMBER_W;
   localparam int TIMEOUT_DEFAULT = 16;
   localparam logic [15:0] BASE_A = 16'd100;
   localparam logic [15:0] BASE_B = 16'd125;
   localparam logic [15:0] BASE_C = 16'd150;
   localparam logic [15:0] BASE_D = 16'd175;
   localparam logic [15:0] PRICE_STEP = 16'd25;
   function automatic logic [1:0] enc4(input logic [3:0] v);
      return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
   endfunction
   function automatic logic [15:0] base_price(input logic [LETTER_W-1:0] l);
      return l == 2'd0 ? BASE_A : l == 2'd1 ? BASE_B : l == 2'd2 ? BASE_C : BASE_D;
   endfunction
endpackage

// File: rtl/test_vending_if.sv
// test_vending_if: coin-acceptor credit level, product switches and the vend result bus.
interface test_vending_if;
   logic [15:0] money_input;
   logic swa, swb, swc, swd;
   logic sw1, sw2, sw3, sw4;
   logic [15:0] change;
   logic [15:0] price;
   logic [3:0] selection;
   logic success;
   modport master(output money_input, swa, swb, swc, swd, sw1, sw2, sw3, sw4,
                  input change, price, selection, success);
   modport slave(input money_input, swa, swb, swc, swd, sw1, sw2, sw3, sw4,
                 output change, price, selection, success);
endinterface

// File: rtl/vend_select_decode.sv
// vend_select_decode: turns the letter/number switch levels into a validity flag, indices and price.
module vend_select_decode
   import vending_pkg::*;
(
   input  logic [3:0]          letters,
   input  logic [3:0]          numbers,
   output logic                valid,
   output logic                any_pressed,
   output logic [LETTER_W-1:0] letter_idx,
   output logic [NUMBER_W-1:0] number_idx,
   output logic [15:0]         price
);
   assign letter_idx = enc4(letters);
   assign number_idx = enc4(numbers);
   assign any_pressed = |{letters, numbers};
   // no number switch decodes as number 1, so zero numbers is still valid
   assign valid = ($countones(letters) == 1) && ($countones(numbers) <= 1);
   assign price = base_price(letter_idx) + PRICE_STEP * {14'd0, number_idx};
endmodule

// File: rtl/test_vending.sv
// test_vending: single-transaction vending controller; vends with change, refunds, or holds on low credit.
module test_vending
   import vending_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input logic           clk,
   input logic           reset,
   test_vending_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   state_t state;
   logic [15:0] credit;
   logic [CNT_W-1:0] cnt;
   logic prev_any;
   logic valid, any_pressed, press;
   logic [LETTER_W-1:0] letter_idx;
   logic [NUMBER_W-1:0] number_idx;
   logic [15:0] dec_price;
   logic [SEL_W-1:0] dec_sel;
   vend_select_decode u_decode (
      .letters    ({bus.swd, bus.swc, bus.swb, bus.swa}),
      .numbers    ({bus.sw4, bus.sw3, bus.sw2, bus.sw1}),
      .valid      (valid),
      .any_pressed(any_pressed),
      .letter_idx (letter_idx),
      .number_idx (number_idx),
      .price      (dec_price)
   );
   assign press = any_pressed && !prev_any;
   assign dec_sel = {letter_idx, number_idx};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         credit        <= '0;
         cnt           <= '0;
         prev_any      <= 1'b0;
         bus.change    <= '0;
         bus.price     <= '0;
         bus.selection <= '0;
         bus.success   <= 1'b0;
      end else begin
         prev_any <= any_pressed;
         case (state)
            IDLE: begin
               credit <= bus.money_input;
               cnt    <= '0;
               if (press) begin
                  bus.price     <= valid ? dec_price : '0;
                  bus.selection <= valid ? dec_sel : '0;
                  bus.success   <= 1'b0;
                  bus.change    <= '0;
               end
               if (bus.money_input != '0) state <= CREDIT;
            end
            CREDIT: begin
               // decisions use last cycle's credit; the new level is captured alongside
               credit <= bus.money_input;
               if (press && valid && credit >= dec_price) begin
                  bus.price     <= dec_price;
                  bus.selection <= dec_sel;
                  bus.success   <= 1'b1;
                  bus.change    <= credit - dec_price;
                  state         <= DONE;
               end else if (press && valid) begin
                  bus.price     <= dec_price;
                  bus.selection <= dec_sel;
                  bus.success   <= 1'b0;
                  bus.change    <= '0;
                  cnt           <= '0;
               end else if (press) begin
                  bus.price     <= '0;
                  bus.selection <= '0;
                  bus.success   <= 1'b0;
                  bus.change    <= credit;
                  state         <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  bus.success <= 1'b0;
                  bus.change  <= credit;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.money_input == '0) begin
                  state       <= IDLE;
                  bus.success <= 1'b0;
                  bus.change  <= '0;
                  cnt         <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_test_vending.sv
// tb_test_vending: directed vector table, hand-written timeout/reset sequences and random stimulus vs a reference model.
module tb_test_vending;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [15:0] money = '0;
   logic [7:0] sw = '0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   test_vending_if bus();
   assign bus.money_input = money;
   assign {bus.sw4, bus.sw3, bus.sw2, bus.sw1, bus.swd, bus.swc, bus.swb, bus.swa} = sw;
   test_vending dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [15:0] money;
      logic [7:0]  sw;
      logic        succ;
      logic [15:0] chg;
      logic [15:0] pr;
      logic [3:0]  sel;
   } vec_t;
   vec_t tv[18];

   // reference model: mode 0 = no coins, 1 = holding credit, 2 = finished awaiting acceptor clear
   int m_mode, m_credit, m_wait;
   bit m_prev;
   int e_change, e_price, e_sel;
   bit e_succ;

   function automatic vec_t mk(int m, int s, int su, int c, int p, int sl);
      vec_t v;
      v.money = 16'(m); v.sw = 8'(s); v.succ = 1'(su);
      v.chg = 16'(c); v.pr = 16'(p); v.sel = 4'(sl);
      return v;
   endfunction

   function automatic void decode(input logic [7:0] s, output bit ok, output int pr, output int sl);
      int nl, nn, li, ni;
      nl = 0; nn = 0; li = 0; ni = 0;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) begin nl++; li = i; end
         if (s[i+4]) begin nn++; ni = i; end
      end
      ok = (nl == 1) && (nn <= 1);
      pr = ok ? 100 + 25 * li + 25 * ni : 0;
      sl = ok ? li * 4 + ni : 0;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_credit = 0; m_wait = 0; m_prev = 0;
      e_change = 0; e_price = 0; e_sel = 0; e_succ = 0;
   endfunction

   function automatic void model_step(input int mon, input logic [7:0] s);
      bit press, ok;
      int pr, sl;
      press = (s != 0) && !m_prev;
      m_prev = (s != 0);
      decode(s, ok, pr, sl);
      if (m_mode == 0) begin
         if (press) begin e_price = pr; e_sel = sl; e_succ = 0; e_change = 0; end
         m_credit = mon; m_wait = 0;
         if (mon != 0) m_mode = 1;
      end else if (m_mode == 1) begin
         if (press && ok && m_credit >= pr) begin
            e_price = pr; e_sel = sl; e_succ = 1; e_change = m_credit - pr; m_mode = 2;
         end else if (press && ok) begin
            e_price = pr; e_sel = sl; e_succ = 0; e_change = 0; m_wait = 0;
         end else if (press) begin
            e_price = 0; e_sel = 0; e_succ = 0; e_change = m_credit; m_mode = 2;
         end else begin
            m_wait++;
            if (m_wait == 16) begin e_change = m_credit; e_succ = 0; m_mode = 2; end
         end
         m_credit = mon;
      end else if (mon == 0) begin
         m_mode = 0; e_succ = 0; e_change = 0;
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int su, input int c, input int p, input int sl);
      chk({tag, ".success"}, int'(bus.success), su);
      chk({tag, ".change"}, int'(bus.change), c);
      chk({tag, ".price"}, int'(bus.price), p);
      chk({tag, ".selection"}, int'(bus.selection), sl);
   endtask

   task automatic tick(input bit cm);
      model_step(int'(money), sw);
      @(posedge clk);
      @(negedge clk);
      if (cm) chk_all("model", int'(e_succ), e_change, e_price, e_sel);
   endtask

   initial begin
      tv[0]  = mk(25, 'h00, 0, 0, 0, 0);
      tv[1]  = mk(50, 'h00, 0, 0, 0, 0);
      tv[2]  = mk(75, 'h00, 0, 0, 0, 0);
      tv[3]  = mk(100, 'h00, 0, 0, 0, 0);
      tv[4]  = mk(100, 'h01, 1, 0, 100, 0);
      tv[5]  = mk(0, 'h00, 0, 0, 100, 0);
      tv[6]  = mk(0, 'h00, 0, 0, 100, 0);
      tv[7]  = mk(200, 'h00, 0, 0, 100, 0);
      tv[8]  = mk(200, 'h22, 1, 50, 150, 5);
      tv[9]  = mk(0, 'h00, 0, 0, 150, 5);
      tv[10] = mk(200, 'h00, 0, 0, 150, 5);
      tv[11] = mk(200, 'h03, 0, 200, 0, 0);
      tv[12] = mk(0, 'h00, 0, 0, 0, 0);
      tv[13] = mk(100, 'h00, 0, 0, 0, 0);
      tv[14] = mk(100, 'h08, 0, 0, 175, 12);
      tv[15] = mk(175, 'h00, 0, 0, 175, 12);
      tv[16] = mk(175, 'h08, 1, 0, 175, 12);
      tv[17] = mk(0, 'h00, 0, 0, 175, 12);
      model_reset();
      #12;
      chk_all("reset", 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 18; i++) begin
         money = tv[i].money;
         sw = tv[i].sw;
         tick(1);
         chk_all($sformatf("vec%0d", i), int'(tv[i].succ), int'(tv[i].chg), int'(tv[i].pr), int'(tv[i].sel));
      end
      // timeout: 16 idle CREDIT cycles refund, then a press in DONE is ignored
      money = 100;
      tick(1);
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk("timeout.early_change", int'(bus.change), 0);
      end
      tick(1);
      chk_all("timeout.fire", 0, 100, 175, 12);
      sw = 8'h01;
      tick(1);
      chk_all("timeout.done_press", 0, 100, 175, 12);
      sw = 8'h00;
      tick(1);
      money = 0;
      tick(1);
      chk_all("timeout.clear", 0, 0, 175, 12);
      // asynchronous reset in the middle of a transaction
      money = 75;
      tick(1);
      money = 200;
      tick(1);
      sw = 8'h21;
      tick(1);
      chk_all("prereset", 1, 75, 125, 1);
      #2 reset = 1'b0;
      #1 chk_all("async_reset", 0, 0, 0, 0);
      model_reset();
      money = 0;
      sw = 8'h00;
      #1 reset = 1'b1;
      tick(1);
      // random traffic against the reference model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0) money = 16'(50 * $urandom_range(0, 6));
         if (m_mode == 2 && $urandom_range(0, 5) == 0) money = 0;
         if (sw != 0) begin
            if ($urandom_range(0, 1) == 0) sw = 8'h00;
         end else if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 3) != 0)
               sw = 8'(1 << $urandom_range(0, 3)) | ($urandom_range(0, 1) ? 8'(16 << $urandom_range(0, 3)) : 8'h00);
            else
               sw = 8'($urandom_range(1, 255));
         end
         tick(1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
